// File: rtl/rv32ima_pkg.sv
// Shared definitions for the CPU <-> RAM memory interface: access widths,
// the RAM handshake state and the basic data word type.
package rv32ima_pkg;

    localparam int LDST_WIDTH_W = 2;

    localparam logic [LDST_WIDTH_W-1:0] LDST_BYTE = 2'd0;
    localparam logic [LDST_WIDTH_W-1:0] LDST_HALF = 2'd1;
    localparam logic [LDST_WIDTH_W-1:0] LDST_WORD = 2'd2;
    localparam logic [LDST_WIDTH_W-1:0] LDST_RSVD = 2'd3;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } ram_state_t;

    // Width code 3 has no defined access size.
    function automatic logic is_reserved_width(input logic [LDST_WIDTH_W-1:0] width);
        return (width == LDST_RSVD);
    endfunction

endpackage

// File: rtl/ram_lane_unit.sv
// Byte-lane steering for byte/half/word accesses into a 32-bit word.
// Purely combinational: produces byte enables and the replicated write word
// for stores, the right-aligned zero-extended result for loads, and an
// alignment flag for half/word requests.
module ram_lane_unit
    import rv32ima_pkg::*;
(
    input  logic [LDST_WIDTH_W-1:0] width,
    input  logic [1:0]              lane,
    input  word_t                   store_data,
    input  word_t                   read_word,
    output logic [3:0]              byte_en,
    output word_t                   write_word,
    output word_t                   load_data,
    output logic                    misalign
);

    word_t shifted_word;

    // Bring the addressed lane down to bit 0 so extraction is a simple mask.
    assign shifted_word = read_word >> {lane, 3'b000};

    // Decode enables, replicate store data across lanes and extract load data.
    always_comb begin
        byte_en    = 4'b0000;
        write_word = store_data;
        load_data  = 32'h0;
        misalign   = 1'b0;
        case (width)
            LDST_BYTE: begin
                byte_en    = 4'b0001 << lane;
                write_word = {4{store_data[7:0]}};
                load_data  = {24'h0, shifted_word[7:0]};
            end
            LDST_HALF: begin
                byte_en    = 4'b0011 << lane;
                write_word = {2{store_data[15:0]}};
                load_data  = {16'h0, shifted_word[15:0]};
                misalign   = lane[0];
            end
            LDST_WORD: begin
                byte_en    = 4'b1111;
                write_word = store_data;
                load_data  = read_word;
                misalign   = (lane != 2'b00);
            end
            default: begin
                byte_en    = 4'b0000;
                write_word = store_data;
                load_data  = 32'h0;
                misalign   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ram_controller.sv
// Single-port RAM model on the RAM side of the CPU memory interface.
// One load/store at a time: request sampled in FREE, held for LATENCY BUSY
// cycles, executed on the last BUSY edge, reported via DONE or ERROR.
module ram_controller
    import rv32ima_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                    ram_clk,
    input  logic                    nrst,
    input  logic [31:0]             ram_addr,
    input  word_t                   ram_store,
    input  logic                    ram_ren,
    input  logic                    ram_wen,
    input  logic [LDST_WIDTH_W-1:0] ram_width,
    output word_t                   ram_load,
    output ram_state_t              ram_state
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    // 33 bits so a 2^30-word array still has a representable span.
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

    // Registered FSM state and latched request
    ram_state_t              state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [1:0]              lane_reg;
    logic [LDST_WIDTH_W-1:0] width_reg;
    word_t                   store_reg;
    logic                    is_store_reg;
    word_t                   load_reg;

    // Memory array and its registered read port
    word_t                   mem [DEPTH_WORDS];
    word_t                   rd_word_reg;

    // Incoming request decode
    word_t                   req_offset;
    logic                    req_in_range;
    logic [IDX_W-1:0]        req_idx;
    logic                    req_any;
    logic                    req_bad;

    // Lane unit connections
    logic [LDST_WIDTH_W-1:0] lu_width;
    logic [1:0]              lu_lane;
    logic [3:0]              lu_byte_en;
    word_t                   lu_write_word;
    word_t                   lu_load_data;
    logic                    lu_misalign;

    logic                    exec;

    // Offset from the array base; addresses below the base wrap to huge
    // values and so fail the range check naturally.
    assign req_offset   = ram_addr - BASE_ADDR;
    assign req_in_range = ({1'b0, req_offset} < SPAN_BYTES);
    assign req_idx      = req_offset[IDX_W+1:2];
    assign req_any      = ram_ren | ram_wen;
    assign req_bad      = (ram_ren & ram_wen) | is_reserved_width(ram_width)
                        | lu_misalign | ~req_in_range;

    // In FREE the lane unit checks the live request for alignment; while an
    // access is in flight it works on the latched copy.
    assign lu_width = (state_reg == FREE) ? ram_width     : width_reg;
    assign lu_lane  = (state_reg == FREE) ? ram_addr[1:0] : lane_reg;

    // The access happens on the last BUSY edge.
    assign exec = (state_reg == BUSY) && (cnt_reg == '0);

    ram_lane_unit u_lane_unit (
        .width      (lu_width),
        .lane       (lu_lane),
        .store_data (store_reg),
        .read_word  (rd_word_reg),
        .byte_en    (lu_byte_en),
        .write_word (lu_write_word),
        .load_data  (lu_load_data),
        .misalign   (lu_misalign)
    );

    // Request FSM with latency counter, request latches and load result.
    always_ff @(posedge ram_clk or negedge nrst) begin
        if (!nrst) begin
            state_reg    <= FREE;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            lane_reg     <= 2'b00;
            width_reg    <= '0;
            store_reg    <= 32'h0;
            is_store_reg <= 1'b0;
            load_reg     <= 32'h0;
        end else begin
            case (state_reg)
                FREE: begin
                    if (req_any) begin
                        if (req_bad) begin
                            state_reg <= ERROR;
                        end else begin
                            state_reg    <= BUSY;
                            cnt_reg      <= CNT_INIT;
                            idx_reg      <= req_idx;
                            lane_reg     <= ram_addr[1:0];
                            width_reg    <= ram_width;
                            store_reg    <= ram_store;
                            is_store_reg <= ram_wen;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_reg == '0) begin
                        state_reg <= DONE;
                        if (!is_store_reg) begin
                            load_reg <= lu_load_data;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE:    state_reg <= FREE;
                ERROR:   state_reg <= FREE;
                default: state_reg <= FREE;
            endcase
        end
    end

    // Array port: read the incoming address while FREE so the word is ready
    // by the execute edge; byte-enabled write on the execute edge of a store.
    always_ff @(posedge ram_clk) begin
        if (state_reg == FREE) begin
            rd_word_reg <= mem[req_idx];
        end
        if (exec && is_store_reg) begin
            for (int b = 0; b < 4; b++) begin
                if (lu_byte_en[b]) begin
                    mem[idx_reg][b*8 +: 8] <= lu_write_word[b*8 +: 8];
                end
            end
        end
    end

    assign ram_state = state_reg;
    assign ram_load  = load_reg;

endmodule

// File: tb/tb_ram_controller.sv
// Directed bench for ram_controller: reset, lane steering, error cases,
// back-to-back timing (LATENCY=2) and a LATENCY=1 instance.
module tb_ram_controller;
    import rv32ima_pkg::*;

    logic        clk;
    logic        nrst;

    logic [31:0] addr;
    logic [31:0] store;
    logic        ren;
    logic        wen;
    logic [1:0]  width;
    logic [31:0] load;
    ram_state_t  state;

    logic [31:0] addr2;
    logic [31:0] store2;
    logic        ren2;
    logic        wen2;
    logic [1:0]  width2;
    logic [31:0] load2;
    ram_state_t  state2;

    int vectors;
    int miscompares;

    ram_controller #(.DEPTH_WORDS(4096), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
        .ram_clk   (clk),
        .nrst      (nrst),
        .ram_addr  (addr),
        .ram_store (store),
        .ram_ren   (ren),
        .ram_wen   (wen),
        .ram_width (width),
        .ram_load  (load),
        .ram_state (state)
    );

    ram_controller #(.DEPTH_WORDS(4096), .LATENCY(1), .BASE_ADDR(32'h0)) dut_l1 (
        .ram_clk   (clk),
        .nrst      (nrst),
        .ram_addr  (addr2),
        .ram_store (store2),
        .ram_ren   (ren2),
        .ram_wen   (wen2),
        .ram_width (width2),
        .ram_load  (load2),
        .ram_state (state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One complete access on the LATENCY=2 instance; the request is held until
    // DONE/ERROR is seen, then dropped.
    task automatic run_op(input string tag, input logic r, input logic w, input logic [1:0] wd,
                          input logic [31:0] a, input logic [31:0] d, input bit err,
                          input logic [31:0] exp_load);
        ren = r; wen = w; width = wd; addr = a; store = d;
        if (err) begin
            step();
            check({tag, " err"}, 32'(state), 32'(ERROR));
            ren = 1'b0; wen = 1'b0;
            step();
            check({tag, " free"}, 32'(state), 32'(FREE));
            check({tag, " load"}, load, exp_load);
        end else begin
            step();
            check({tag, " busy1"}, 32'(state), 32'(BUSY));
            step();
            check({tag, " busy2"}, 32'(state), 32'(BUSY));
            step();
            check({tag, " done"}, 32'(state), 32'(DONE));
            check({tag, " load"}, load, exp_load);
            ren = 1'b0; wen = 1'b0;
            step();
            check({tag, " free"}, 32'(state), 32'(FREE));
        end
        $display("op %s addr=%08h width=%0d data=%08h load=%08h", tag, a, wd, d, load);
    endtask

    initial begin
        int gap;
        vectors = 0;
        miscompares = 0;
        nrst = 1'b0;
        addr = 32'h0; store = 32'h0; ren = 1'b0; wen = 1'b0; width = 2'd0;
        addr2 = 32'h0; store2 = 32'h0; ren2 = 1'b0; wen2 = 1'b0; width2 = 2'd0;

        step();
        step();
        check("reset state", 32'(state), 32'(FREE));
        check("reset load", load, 32'h0);
        #2 nrst = 1'b1;

        run_op("st 0x10", 1'b0, 1'b1, LDST_WORD, 32'h10, 32'h0BAD_F00D, 1'b0, 32'h0);
        run_op("ld 0x10", 1'b1, 1'b0, LDST_WORD, 32'h10, 32'h0, 1'b0, 32'h0BAD_F00D);

        // Reset while a store is in BUSY: store must be dropped.
        ren = 1'b0; wen = 1'b1; width = LDST_WORD; addr = 32'h10; store = 32'hDEAD_BEEF;
        step();
        check("midrst busy", 32'(state), 32'(BUSY));
        nrst = 1'b0;
        wen = 1'b0;
        #1;
        check("midrst state", 32'(state), 32'(FREE));
        check("midrst load", load, 32'h0);
        #2 nrst = 1'b1;
        step();
        check("post rst idle", 32'(state), 32'(FREE));
        run_op("ld 0x10 kept", 1'b1, 1'b0, LDST_WORD, 32'h10, 32'h0, 1'b0, 32'h0BAD_F00D);

        run_op("st 0x20", 1'b0, 1'b1, LDST_WORD, 32'h20, 32'h1234_5678, 1'b0, 32'h0BAD_F00D);
        run_op("ld 0x20", 1'b1, 1'b0, LDST_WORD, 32'h20, 32'h0, 1'b0, 32'h1234_5678);
        run_op("stb 0x22", 1'b0, 1'b1, LDST_BYTE, 32'h22, 32'h0000_00AA, 1'b0, 32'h1234_5678);
        run_op("ld 0x20 b", 1'b1, 1'b0, LDST_WORD, 32'h20, 32'h0, 1'b0, 32'h12AA_5678);
        run_op("ldh 0x22", 1'b1, 1'b0, LDST_HALF, 32'h22, 32'h0, 1'b0, 32'h0000_12AA);
        run_op("ldb 0x23", 1'b1, 1'b0, LDST_BYTE, 32'h23, 32'h0, 1'b0, 32'h0000_0012);

        run_op("err ldh 0x21", 1'b1, 1'b0, LDST_HALF, 32'h21, 32'h0, 1'b1, 32'h0000_0012);
        run_op("err stw 0x22", 1'b0, 1'b1, LDST_WORD, 32'h22, 32'hFFFF_FFFF, 1'b1, 32'h0000_0012);
        run_op("err width3", 1'b0, 1'b1, LDST_RSVD, 32'h20, 32'hFFFF_FFFF, 1'b1, 32'h0000_0012);
        run_op("err ren+wen", 1'b1, 1'b1, LDST_WORD, 32'h20, 32'hFFFF_FFFF, 1'b1, 32'h0000_0012);
        run_op("err range", 1'b0, 1'b1, LDST_WORD, 32'h4000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0012);
        run_op("ld after err", 1'b1, 1'b0, LDST_WORD, 32'h20, 32'h0, 1'b0, 32'h12AA_5678);

        run_op("sth 0x20", 1'b0, 1'b1, LDST_HALF, 32'h20, 32'h0000_BEEF, 1'b0, 32'h12AA_5678);
        run_op("ld 0x20 h", 1'b1, 1'b0, LDST_WORD, 32'h20, 32'h0, 1'b0, 32'h12AA_BEEF);
        run_op("ldb 0x21", 1'b1, 1'b0, LDST_BYTE, 32'h21, 32'h0, 1'b0, 32'h0000_00BE);

        // Back-to-back: hold a load through DONE and time the second DONE.
        ren = 1'b1; wen = 1'b0; width = LDST_WORD; addr = 32'h10;
        step(); step(); step();
        check("b2b first done", 32'(state), 32'(DONE));
        check("b2b first load", load, 32'h0BAD_F00D);
        addr = 32'h20;
        gap = 0;
        do begin
            step();
            gap++;
        end while (state != DONE && gap < 10);
        check("b2b gap", 32'(gap), 32'd4);
        check("b2b second load", load, 32'h12AA_BEEF);
        ren = 1'b0;
        step();
        check("b2b free", 32'(state), 32'(FREE));
        $display("op b2b gap=%0d load=%08h", gap, load);

        // LATENCY=1 instance: exactly one BUSY cycle per access.
        wen2 = 1'b1; width2 = LDST_WORD; addr2 = 32'h4; store2 = 32'hCAFE_0001;
        step();
        check("l1 st busy", 32'(state2), 32'(BUSY));
        step();
        check("l1 st done", 32'(state2), 32'(DONE));
        wen2 = 1'b0;
        step();
        check("l1 st free", 32'(state2), 32'(FREE));
        ren2 = 1'b1;
        step();
        check("l1 ld busy", 32'(state2), 32'(BUSY));
        step();
        check("l1 ld done", 32'(state2), 32'(DONE));
        check("l1 ld data", load2, 32'hCAFE_0001);
        ren2 = 1'b0;
        step();
        check("l1 ld free", 32'(state2), 32'(FREE));
        $display("op l1 ld addr=%08h load=%08h", addr2, load2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_controller.md
# ram_controller

Synchronous single-port RAM model that implements the RAM side of `cpu_ram_if` and sits directly downstream of the CPU memory stage. It accepts one load or store at a time, holds it for a parameterised access latency and performs byte, half or word access with byte-lane steering. It reports progress and errors through `ram_state`.

## Interface
- `DEPTH_WORDS`, default 4096: number of 32-bit words in the array.
- `LATENCY`, default 2: number of BUSY cycles per access; legal range ≥1.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0.
- `ram_clk` input 1: sole clock; all state updates on the rising edge.
- `nrst` input 1: reset, asynchronous, active-low.
- `ram_addr` input 32: byte address of the request.
- `ram_store` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `ram_ren` input 1: load request.
- `ram_wen` input 1: store request.
- `ram_width` input LDST_WIDTH_W: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- `ram_load` output 32: load data, right-aligned and zero-extended. Sign extension belongs to the CPU.
- `ram_state` output ram_state_t: FREE, BUSY, DONE or ERROR.

## Operation
- FSM states are FREE, BUSY, DONE and ERROR; `ram_state` is the registered state.
- **FREE:** samples the request every edge.
  - `ram_ren`=`ram_wen`=0: stay in FREE.
  - A valid request: latch addr, store data, width and op, load latency counter with LATENCY-1, go to BUSY.
  - An invalid request: go to ERROR. Invalid means any of the following:
    - both `ram_ren` and `ram_wen` high;
    - width 3;
    - half with addr[0]=1;
    - word with addr[1:0]≠0;
    - (addr−BASE_ADDR) ≥ 4·DEPTH_WORDS, computed as an unsigned 32-bit compare. Addresses below BASE_ADDR wrap and are therefore out of range.
- **BUSY:** the counter decrements each edge. On the edge where the counter is 0, the access executes and the FSM goes to DONE. Request inputs are ignored while BUSY, because the latched copy is used.
- **Access:**
  - Word index = (addr−BASE_ADDR)[31:2]; lane = addr[1:0].
  - Store: writes only the enabled bytes. Byte uses lane `lane`; half uses lanes {lane+1, lane}; word uses all four lanes. Other bytes are unchanged.
  - Load: extracts the same lanes into `ram_load` right-aligned and zero-fills the upper bits.
  - Store leaves `ram_load` unchanged.
- **DONE:** lasts 1 cycle, then always goes to FREE.
- **ERROR:** lasts 1 cycle, then always goes to FREE. The array and `ram_load` are untouched.
- `ram_load` holds its value until the next completed load.
- **Handshake:** the CPU holds the request until it sees DONE or ERROR. It then deasserts the request or presents a new one on the following edge, and the controller samples it in the next FREE cycle. A request still asserted in FREE after DONE is treated as a new access.

## Timing
- **Reset:** while `nrst`=0, asynchronously `ram_state`=FREE, `ram_load`=32'h0, counter=0 and latched request registers are cleared. Array contents are not reset.
- **Reset mid-operation:** a pending store in BUSY is discarded and no array write occurs. The first request after reset release is sampled on the first rising edge with `nrst`=1.
- **Valid request latency:**
  - Accepted at edge E0.
  - BUSY for cycles 1..LATENCY.
  - DONE in cycle LATENCY+1, with `ram_load` valid in that same cycle.
- **Invalid request latency:** ERROR in cycle 1.
- **Throughput:** one access per LATENCY+2 cycles (FREE, BUSY×LATENCY, DONE).
- **LATENCY=1:** exactly one BUSY cycle.

## Structure
- Package `rv32ima_pkg` holds the shared definitions:
  - `ram_state_t` (2-bit enum FREE=0, BUSY=1, DONE=2, ERROR=3);
  - width encodings `LDST_BYTE`, `LDST_HALF` and `LDST_WORD`;
  - `LDST_WIDTH_W`=2 and `word_t`.
- Sub-module `ram_lane_unit` is purely combinational. Its inputs are width, addr[1:0], store data and the read word. Its outputs are the 4-bit byte-enable, the lane-shifted write word, the extracted load data and the misalign flag.
- Top level contains the FSM, counter, latched request registers and the array.

## Test plan
- **Reset:** reset asserted mid-BUSY on a word store of 32'hDEAD_BEEF to 0x10 → state FREE and `ram_load`=0 immediately; a later word load from 0x10 returns the prior contents.
- **Word round-trip, LATENCY=2:** word store 32'h1234_5678 to 0x20, then word load from 0x20 → DONE in cycle 3 after acceptance and `ram_load`=32'h1234_5678.
- **Byte/half lanes:** after word 32'h1234_5678 at 0x20:
  - byte store 8'hAA to 0x22 → word load returns 32'h12AA_5678;
  - half load from 0x22 returns 32'h0000_12AA;
  - byte load from 0x23 returns 32'h0000_0012.
- **Errors:** each of the following → ERROR for 1 cycle, then FREE, with the array unchanged:
  - half load at 0x21;
  - word store at 0x22;
  - width 3;
  - `ram_ren`=`ram_wen`=1;
  - addr BASE_ADDR+4·DEPTH_WORDS.
- **Back-to-back:** request held high through DONE → second access accepted in the following FREE cycle, and the second DONE occurs exactly LATENCY+2 cycles after the first.
- **LATENCY=1 build:** word load → exactly one BUSY cycle, then DONE.
